param_sp_ram: RTL and testbench

Parametrised single-port synchronous RAM; successor to the fixed 64x8 single-port RAM. Generalised in width and depth, with per-byte write enables, a selectable read-during-write mode, an optional output pipeline register, and a self-clearing engine that fills memory with a known value after reset or on request. Used as the scratch and buffer memory in downstream datapaths.

---
 rtl/param_sp_ram.sv | 119 +++++++++++
 tb/tb_param_sp_ram.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sp_ram.sv
// Parametrised single-port synchronous RAM with byte enables, selectable read-during-write
// behaviour, optional output register and a clear engine that fills memory with CLEAR_VAL.
module param_sp_ram #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    RDW_MODE   = 0,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   indata,
  input  logic                    clr,
  output logic [DATA_WIDTH-1:0]   outdata,
  output logic                    rvalid,
  output logic                    busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc;
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic [DATA_WIDTH-1:0]   resp_d;
  logic                    s1_vld_q;
  logic [DATA_WIDTH-1:0]   s1_dat_q;

  // clr outranks en, so a request in the same cycle as clr is dropped
  assign acc      = (state_q == ST_IDLE) && !clr && en;
  assign busy     = (state_q == ST_CLEAR);
  assign old_word = mem[addr];

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged_word[8*i +: 8] = indata[8*i +: 8];
    end
  end

  assign resp_d = (wr && RDW_MODE == 1) ? merged_word : old_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_ADDR) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (clr) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // storage itself is never reset; the clear engine initialises it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_ptr_q] <= CLEAR_VAL;
      end else if (acc && wr) begin
        mem[addr] <= merged_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= acc;
      if (acc) s1_dat_q <= resp_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s2_vld_q;
      logic [DATA_WIDTH-1:0] s2_dat_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) s2_dat_q <= s1_dat_q;
        end
      end

      assign outdata = s2_dat_q;
      assign rvalid  = s2_vld_q;
    end else begin : g_no_out_reg
      assign outdata = s1_dat_q;
      assign rvalid  = s1_vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_sp_ram.sv
// Bench for param_sp_ram: four configurations driven in lockstep, checked against a
// cycle-level reference model plus directed vector tables and corner-case sequences.
module tb_param_sp_ram;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst, en, wr, clr;
  logic [1:0]  be;
  logic [5:0]  addr;
  logic [15:0] indata;

  logic [7:0]  out0, out2;
  logic [15:0] out1, out3;
  logic [15:0] d_out  [NI];
  logic        d_vld  [NI];
  logic        d_busy [NI];

  int          cfg_w   [NI] = '{8, 16, 8, 16};
  int          cfg_rdw [NI] = '{0, 1, 0, 0};
  int          cfg_lat [NI] = '{1, 1, 2, 2};
  logic [15:0] cfg_clr [NI] = '{16'h0000, 16'h5AC3, 16'h0000, 16'hC3A5};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  param_sp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(0), .OUT_REG(0), .CLEAR_VAL(8'h00)) u0 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .be(be[0:0]), .addr(addr), .indata(indata[7:0]),
    .clr(clr), .outdata(out0), .rvalid(d_vld[0]), .busy(d_busy[0]));
  param_sp_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RDW_MODE(1), .OUT_REG(0), .CLEAR_VAL(16'h5AC3)) u1 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .be(be), .addr(addr), .indata(indata),
    .clr(clr), .outdata(out1), .rvalid(d_vld[1]), .busy(d_busy[1]));
  param_sp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(0), .OUT_REG(1), .CLEAR_VAL(8'h00)) u2 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .be(be[0:0]), .addr(addr), .indata(indata[7:0]),
    .clr(clr), .outdata(out2), .rvalid(d_vld[2]), .busy(d_busy[2]));
  param_sp_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RDW_MODE(0), .OUT_REG(1), .CLEAR_VAL(16'hC3A5)) u3 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .be(be), .addr(addr), .indata(indata),
    .clr(clr), .outdata(out3), .rvalid(d_vld[3]), .busy(d_busy[3]));

  assign d_out[0] = {8'h00, out0};
  assign d_out[1] = out1;
  assign d_out[2] = {8'h00, out2};
  assign d_out[3] = out3;

  // Reference model: memory image, clear cycles still owed, and a queue of promised responses
  typedef struct {
    logic [15:0] d;
    int          due;
  } resp_t;

  logic [15:0] m_mem [NI][64];
  int          m_clear_left [NI];
  logic [15:0] m_out [NI];
  logic        m_vld [NI];
  resp_t       pq [NI][$];

  task automatic model_edge();
    logic [15:0] old_w, new_w;
    resp_t       r;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_clear_left[k] = 64;
        pq[k].delete();
        m_out[k] = '0;
        m_vld[k] = 1'b0;
      end else begin
        if (m_clear_left[k] > 0) begin
          m_mem[k][64 - m_clear_left[k]] = cfg_clr[k];
          m_clear_left[k]--;
        end else if (clr) begin
          m_clear_left[k] = 64;
        end else if (en) begin
          old_w = m_mem[k][addr];
          new_w = old_w;
          for (int i = 0; i < cfg_w[k] / 8; i++)
            if (be[i]) new_w[8*i +: 8] = indata[8*i +: 8];
          if (wr) m_mem[k][addr] = new_w;
          r.d   = (wr && cfg_rdw[k] == 1) ? new_w : old_w;
          r.due = cyc + cfg_lat[k] - 1;
          pq[k].push_back(r);
        end
        if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
          m_vld[k] = 1'b1;
          m_out[k] = pq[k][0].d;
          void'(pq[k].pop_front());
        end else begin
          m_vld[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d_busy", k), {15'h0, d_busy[k]}, {15'h0, m_clear_left[k] > 0});
      chk($sformatf("u%0d_rvalid", k), {15'h0, d_vld[k]}, {15'h0, m_vld[k]});
      chk($sformatf("u%0d_outdata", k), d_out[k], m_out[k]);
    end
  endtask

  task automatic idle_inputs();
    en = 1'b0; wr = 1'b0; be = 2'b00; addr = '0; indata = '0; clr = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (d_busy[0] && n < 200) begin
      n++;
      step();
    end
    chk(name, 16'(n), 16'd64);
  endtask

  typedef struct {
    logic        en, wr;
    logic [1:0]  be;
    logic [5:0]  addr;
    logic [15:0] din;
    logic        clr;
    logic        vld;
    logic [7:0]  dat0;
    logic [15:0] dat1;
  } vec_t;

  vec_t vt [19];

  initial begin
    // {en, wr, be, addr, din, clr} -> u0 rvalid/outdata and u1 outdata after the edge
    vt[0]  = '{1'b1, 1'b0, 2'b00, 6'h00, 16'h0000, 1'b0, 1'b1, 8'h00, 16'h5AC3};
    vt[1]  = '{1'b1, 1'b0, 2'b00, 6'h0A, 16'h0000, 1'b0, 1'b1, 8'h00, 16'h5AC3};
    vt[2]  = '{1'b1, 1'b0, 2'b00, 6'h3F, 16'h0000, 1'b0, 1'b1, 8'h00, 16'h5AC3};
    vt[3]  = '{1'b0, 1'b0, 2'b00, 6'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h5AC3};
    vt[4]  = '{1'b1, 1'b1, 2'b01, 6'h0A, 16'h00AA, 1'b0, 1'b1, 8'h00, 16'h5AAA};
    vt[5]  = '{1'b1, 1'b1, 2'b01, 6'h0C, 16'h00AB, 1'b0, 1'b1, 8'h00, 16'h5AAB};
    vt[6]  = '{1'b1, 1'b0, 2'b00, 6'h0A, 16'h0000, 1'b0, 1'b1, 8'hAA, 16'h5AAA};
    vt[7]  = '{1'b1, 1'b0, 2'b00, 6'h0C, 16'h0000, 1'b0, 1'b1, 8'hAB, 16'h5AAB};
    vt[8]  = '{1'b0, 1'b0, 2'b00, 6'h00, 16'h0000, 1'b0, 1'b0, 8'hAB, 16'h5AAB};
    vt[9]  = '{1'b1, 1'b1, 2'b01, 6'h0A, 16'h0055, 1'b0, 1'b1, 8'hAA, 16'h5A55};
    vt[10] = '{1'b1, 1'b1, 2'b01, 6'h0A, 16'h0066, 1'b0, 1'b1, 8'h55, 16'h5A66};
    vt[11] = '{1'b1, 1'b0, 2'b00, 6'h0A, 16'h0000, 1'b0, 1'b1, 8'h66, 16'h5A66};
    vt[12] = '{1'b1, 1'b1, 2'b00, 6'h0A, 16'h0077, 1'b0, 1'b1, 8'h66, 16'h5A66};
    vt[13] = '{1'b1, 1'b0, 2'b00, 6'h0A, 16'h0000, 1'b0, 1'b1, 8'h66, 16'h5A66};
    vt[14] = '{1'b0, 1'b0, 2'b00, 6'h00, 16'h0000, 1'b0, 1'b0, 8'h66, 16'h5A66};
    vt[15] = '{1'b1, 1'b1, 2'b11, 6'h05, 16'h1234, 1'b0, 1'b1, 8'h00, 16'h1234};
    vt[16] = '{1'b1, 1'b1, 2'b01, 6'h05, 16'hABCD, 1'b0, 1'b1, 8'h34, 16'h12CD};
    vt[17] = '{1'b1, 1'b0, 2'b00, 6'h05, 16'h0000, 1'b0, 1'b1, 8'hCD, 16'h12CD};
    vt[18] = '{1'b0, 1'b0, 2'b00, 6'h00, 16'h0000, 1'b0, 1'b0, 8'hCD, 16'h12CD};

    for (int k = 0; k < NI; k++) begin
      m_clear_left[k] = 0;
      m_out[k] = '0;
      m_vld[k] = 1'b0;
      for (int a = 0; a < 64; a++) m_mem[k][a] = '0;
    end

    idle_inputs();
    rst = 1'b1;
    #1;
    step();
    step();
    chk("rst_busy", {15'h0, d_busy[0]}, 16'h0001);
    chk("rst_rvalid", {15'h0, d_vld[0]}, 16'h0000);
    chk("rst_outdata", d_out[1], 16'h0000);
    rst = 1'b0;
    count_busy("clear_len_after_rst");
    step();

    for (int v = 0; v < 19; v++) begin
      en = vt[v].en; wr = vt[v].wr; be = vt[v].be;
      addr = vt[v].addr; indata = vt[v].din; clr = vt[v].clr;
      step();
      chk($sformatf("vec%0d_u0_rvalid", v), {15'h0, d_vld[0]}, {15'h0, vt[v].vld});
      chk($sformatf("vec%0d_u0_outdata", v), d_out[0], {8'h00, vt[v].dat0});
      chk($sformatf("vec%0d_u1_outdata", v), d_out[1], vt[v].dat1);
    end

    // OUT_REG=1: response must appear two edges after the request, not one
    en = 1'b1; wr = 1'b0; addr = 6'h0C;
    step();
    chk("oreg_u0_rvalid_lat1", {15'h0, d_vld[0]}, 16'h0001);
    chk("oreg_u2_rvalid_early", {15'h0, d_vld[2]}, 16'h0000);
    idle_inputs();
    step();
    chk("oreg_u2_rvalid_lat2", {15'h0, d_vld[2]}, 16'h0001);
    chk("oreg_u2_outdata", d_out[2], 16'h00AB);
    step();

    // clr together with a read: the read is dropped and a full clear follows
    en = 1'b1; wr = 1'b0; addr = 6'h0C; clr = 1'b1;
    step();
    chk("clr_drop_rvalid", {15'h0, d_vld[0]}, 16'h0000);
    chk("clr_busy", {15'h0, d_busy[0]}, 16'h0001);
    idle_inputs();
    count_busy("clear_len_after_clr");
    en = 1'b1; addr = 6'h0C;
    step();
    chk("post_clr_u0_read", d_out[0], 16'h0000);
    chk("post_clr_u1_read", d_out[1], 16'h5AC3);
    idle_inputs();
    step();

    // reset in the middle of a clear restarts it
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1; en = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;
    count_busy("clear_len_after_mid_rst");

    for (int n = 0; n < 3000; n++) begin
      en     = ($urandom % 4) != 0;
      wr     = $urandom % 2;
      be     = 2'($urandom % 4);
      addr   = 6'(($urandom % 3 == 0) ? $urandom % 64 : $urandom % 8);
      indata = 16'($urandom);
      clr    = ($urandom % 200) == 0;
      rst    = ($urandom % 600) == 0;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
